// File: rtl/panic_noc_credit_tx.sv
// Purpose: credit-gated packet injector into the NoC, one credit counter per destination node.
// Latency: one register stage from s_axis to m_axis, full throughput.
// Backpressure: head beats wait for a credit; any beat waits while the output register is held.
module panic_noc_credit_tx #(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = DATA_WIDTH/8,
  parameter int DEST_WIDTH      = 3,
  parameter int USER_WIDTH      = 1,
  parameter int INIT_CREDIT_NUM = 2,
  parameter int CREDIT_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  input  logic                    credit_ret_valid,
  input  logic [DEST_WIDTH-1:0]   credit_ret_dest,
  output logic [2**DEST_WIDTH-1:0] credit_avail,
  output logic                    credit_err
);

  localparam int NODE_NUM = 2**DEST_WIDTH;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_INIT = CREDIT_WIDTH'(INIT_CREDIT_NUM);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]              state_q;
  logic [DEST_WIDTH-1:0]   dest_q;
  logic [CREDIT_WIDTH-1:0] credit_q [NODE_NUM];
  logic                    run_q;

  logic                    gate;
  logic                    out_free;
  logic                    s_hs;
  logic                    head_hs;
  logic [NODE_NUM-1:0]     take_vec;
  logic [NODE_NUM-1:0]     give_vec;
  logic [NODE_NUM-1:0]     full_vec;

  // Handshake gating: heads need a credit, body beats only need room in the output register.
  always_comb begin
    gate          = (state_q == ST_BURST) || (credit_q[s_axis_tdest] != '0);
    out_free      = !m_axis_tvalid || m_axis_tready;
    s_axis_tready = run_q && gate && out_free;
    s_hs          = s_axis_tvalid && s_axis_tready;
    head_hs       = s_hs && (state_q == ST_IDLE);
  end

  // Per-destination consume/return/saturation decode.
  always_comb begin
    take_vec     = '0;
    give_vec     = '0;
    full_vec     = '0;
    credit_avail = '0;
    for (int d = 0; d < NODE_NUM; d++) begin
      take_vec[d]     = head_hs && (s_axis_tdest == DEST_WIDTH'(d));
      give_vec[d]     = credit_ret_valid && (credit_ret_dest == DEST_WIDTH'(d));
      full_vec[d]     = (credit_q[d] == CREDIT_INIT);
      credit_avail[d] = (credit_q[d] != '0);
    end
  end

  // Ready is held low through reset and comes up on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end

  // Packet framing: a head beat latches its destination for the rest of the packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
    end else if (s_hs) begin
      if (state_q == ST_IDLE) begin
        dest_q  <= s_axis_tdest;
        state_q <= s_axis_tlast ? ST_IDLE : ST_BURST;
      end else if (s_axis_tlast) begin
        state_q <= ST_IDLE;
      end
    end
  end

  // Credit counters: consume on head, return on credit_ret; a same-cycle pair cancels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < NODE_NUM; d++) credit_q[d] <= CREDIT_INIT;
    end else begin
      for (int d = 0; d < NODE_NUM; d++) begin
        if (take_vec[d] && !give_vec[d]) begin
          credit_q[d] <= credit_q[d] - 1'b1;
        end else if (give_vec[d] && !take_vec[d] && !full_vec[d]) begin
          credit_q[d] <= credit_q[d] + 1'b1;
        end
      end
    end
  end

  // Sticky overflow flag: a return to an already-full counter is dropped and flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    credit_err <= 1'b0;
    else if (|(give_vec & ~take_vec & full_vec)) credit_err <= 1'b1;
  end

  // Output register: loads on handshake, holds while the switch stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdest  <= '0;
      m_axis_tuser  <= '0;
    end else if (out_free) begin
      m_axis_tvalid <= s_hs;
      if (s_hs) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tkeep <= s_axis_tkeep;
        m_axis_tlast <= s_axis_tlast;
        m_axis_tuser <= s_axis_tuser;
        m_axis_tdest <= (state_q == ST_BURST) ? dest_q : s_axis_tdest;
      end
    end
  end

endmodule

// File: tb/tb_panic_noc_credit_tx.sv
// Bench for panic_noc_credit_tx: directed table, corner sequences, randomized run vs reference model.
module tb_panic_noc_credit_tx;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int NW = 3;
  localparam int UW = 1;
  localparam int INIT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tready, s_tlast;
  logic [NW-1:0] s_tdest;
  logic [UW-1:0] s_tuser;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tready, m_tlast;
  logic [NW-1:0] m_tdest;
  logic [UW-1:0] m_tuser;
  logic          ret_vld;
  logic [NW-1:0] ret_dest;
  logic [7:0]    avail;
  logic          err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  panic_noc_credit_tx #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEST_WIDTH(NW), .USER_WIDTH(UW),
    .INIT_CREDIT_NUM(INIT), .CREDIT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tdest(s_tdest),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tdest(m_tdest),
    .m_axis_tuser(m_tuser),
    .credit_ret_valid(ret_vld), .credit_ret_dest(ret_dest),
    .credit_avail(avail), .credit_err(err)
  );

  typedef struct {
    logic       vld;
    logic [2:0] dest;
    logic       last;
    logic       rv;
    logic [2:0] rd;
    logic       e_rdy;
    logic [7:0] e_avail;
    logic       e_err;
    logic       e_mvld;
    logic [2:0] e_mdest;
  } vec_t;

  vec_t tbl [13];

  // reference model state
  int         cred [8];
  bit         mdl_burst, mdl_full, mdl_err;
  logic [2:0] mdl_dest;
  logic [40:0] mdl_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] d, input logic [31:0] dat, input logic l);
    s_tvalid = v;
    s_tdest  = d;
    s_tdata  = dat;
    s_tkeep  = dat[3:0] ^ 4'hA;
    s_tuser  = dat[0];
    s_tlast  = l;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 1'b0);
    ret_vld  = 1'b0;
    ret_dest = 3'd0;
    m_tready = 1'b1;
    @(negedge clk);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_avail", avail, 8'hFF);
    chk("rst_err", err, 0);
    chk("rst_m_fields", {m_tdata, m_tkeep, m_tuser, m_tlast, m_tdest}, 0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_low_after_release", s_tready, 0);
  endtask

  initial begin
    //                vld dest last rv rd  rdy avail  err mvld mdest
    tbl[0]  = '{1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b1, 8'hFF, 1'b0, 1'b1, 3'd2};
    tbl[2]  = '{1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 8'hFB, 1'b0, 1'b1, 3'd2};
    tbl[3]  = '{1'b1, 3'd2, 1'b1, 1'b1, 3'd2, 1'b0, 8'hFB, 1'b0, 1'b0, 3'd0};
    tbl[4]  = '{1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0};
    tbl[5]  = '{1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b1, 8'hFB, 1'b0, 1'b1, 3'd2};
    tbl[6]  = '{1'b1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 8'hFB, 1'b0, 1'b1, 3'd3};
    tbl[7]  = '{1'b0, 3'd3, 1'b0, 1'b1, 3'd2, 1'b1, 8'hFB, 1'b0, 1'b1, 3'd3};
    tbl[8]  = '{1'b0, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0};
    tbl[9]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0};
    tbl[10] = '{1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0};
    tbl[11] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0};
    tbl[12] = '{1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0};

    rst = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 1'b0);
    ret_vld = 1'b0; ret_dest = 3'd0; m_tready = 1'b1;

    // ---- table: single-beat credit exhaustion, same-cycle cancel, overflow
    do_reset();
    for (int i = 0; i < 13; i++) begin
      nxt();
      drive(tbl[i].vld, tbl[i].dest, 32'(i), tbl[i].last);
      ret_vld  = tbl[i].rv;
      ret_dest = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("tbl%0d_s_tready", i), s_tready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_avail", i), avail, tbl[i].e_avail);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      chk($sformatf("tbl%0d_m_tvalid", i), m_tvalid, tbl[i].e_mvld);
      if (tbl[i].e_mvld) chk($sformatf("tbl%0d_m_tdest", i), m_tdest, tbl[i].e_mdest);
    end
    nxt();
    drive(1'b0, 3'd0, 32'd0, 1'b0);
    ret_vld = 1'b0;

    // ---- 3-beat packet to dest 5, one-cycle latency
    do_reset();
    for (int i = 0; i < 5; i++) begin
      nxt();
      if (i < 3) drive(1'b1, 3'd5, 32'hA0 + 32'(i), i == 2);
      else       drive(1'b0, 3'd0, 32'd0, 1'b0);
      @(negedge clk);
      if (i < 3) chk("p5_s_tready", s_tready, 1);
      if (i == 0) chk("p5_latency_m_tvalid", m_tvalid, 0);
      if (i >= 1 && i <= 3) begin
        chk("p5_m_tvalid", m_tvalid, 1);
        chk("p5_m_tdata", m_tdata, 32'hA0 + 32'(i - 1));
        chk("p5_m_tdest", m_tdest, 5);
        chk("p5_m_tlast", m_tlast, i == 3);
        chk("p5_avail5", avail[5], 1);
      end
      if (i == 4) chk("p5_drained", m_tvalid, 0);
    end

    // ---- destination latched on head; body-beat tdest ignored
    do_reset();
    for (int i = 0; i < 5; i++) begin
      nxt();
      if (i < 4) drive(1'b1, (i == 0) ? 3'd1 : 3'd6, 32'hB0 + 32'(i), i == 3);
      else       drive(1'b0, 3'd0, 32'd0, 1'b0);
      @(negedge clk);
      if (i > 0) begin
        chk("lat_m_tvalid", m_tvalid, 1);
        chk("lat_m_tdata", m_tdata, 32'hB0 + 32'(i - 1));
        chk("lat_m_tdest", m_tdest, 1);
      end
    end
    nxt();
    ret_vld = 1'b1; ret_dest = 3'd6;
    @(negedge clk);
    chk("lat_err_before", err, 0);
    nxt();
    ret_vld = 1'b0;
    @(negedge clk);
    chk("lat_dest6_still_full", err, 1);
    nxt();
    @(negedge clk);
    chk("lat_err_sticky", err, 1);

    // ---- output stall mid-packet, then reset mid-packet
    do_reset();
    nxt();
    drive(1'b1, 3'd0, 32'hC0, 1'b0);
    @(negedge clk);
    chk("stall_head_ready", s_tready, 1);
    nxt();
    drive(1'b1, 3'd0, 32'hC1, 1'b0);
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_s_tready", s_tready, 0);
      chk("stall_m_tvalid", m_tvalid, 1);
      chk("stall_hold", {m_tdata, m_tkeep, m_tuser, m_tlast, m_tdest},
          {32'hC0, 4'h0 ^ 4'hA, 1'b0, 1'b0, 3'd0});
      nxt();
    end
    m_tready = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", s_tready, 1);
    chk("stall_release_data", m_tdata, 32'hC0);
    nxt();
    drive(1'b1, 3'd0, 32'hC2, 1'b0);
    @(negedge clk);
    chk("stall_next_data", m_tdata, 32'hC1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      nxt();
      @(negedge clk);
      chk("no_trailing_beat", m_tvalid, 0);
    end

    // ---- randomized run against reference model
    do_reset();
    for (int d = 0; d < 8; d++) cred[d] = INIT;
    mdl_burst = 0; mdl_full = 0; mdl_err = 0; mdl_dest = 3'd0;
    mdl_q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] ea;
      bit free, erdy, hs, head;
      nxt();
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0);
      m_tready = $urandom_range(0, 3) != 0;
      ret_vld  = $urandom_range(0, 7) == 0;
      ret_dest = 3'($urandom_range(0, 7));
      @(negedge clk);
      free = !mdl_full || m_tready;
      erdy = (mdl_burst || cred[s_tdest] > 0) && free;
      for (int d = 0; d < 8; d++) ea[d] = cred[d] > 0;
      chk("rnd_s_tready", s_tready, erdy);
      chk("rnd_avail", avail, ea);
      chk("rnd_err", err, mdl_err);
      chk("rnd_m_tvalid", m_tvalid, mdl_full);
      if (mdl_full && mdl_q.size() > 0) begin
        chk("rnd_beat", {m_tdata, m_tkeep, m_tuser, m_tlast, m_tdest}, mdl_q[0]);
        if (m_tready) void'(mdl_q.pop_front());
      end
      hs   = s_tvalid && erdy;
      head = hs && !mdl_burst;
      if (hs) mdl_q.push_back({s_tdata, s_tkeep, s_tuser, s_tlast, mdl_burst ? mdl_dest : s_tdest});
      if (head) begin
        cred[s_tdest] = cred[s_tdest] - 1;
        mdl_dest = s_tdest;
      end
      if (hs) mdl_burst = !s_tlast;
      if (ret_vld) begin
        if (head && s_tdest == ret_dest)  cred[ret_dest] = cred[ret_dest] + 1;
        else if (cred[ret_dest] >= INIT)  mdl_err = 1;
        else                              cred[ret_dest] = cred[ret_dest] + 1;
      end
      mdl_full = (mdl_full && !m_tready) || hs;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
